// File: rtl/fw_rv_addr_line_en_wb_initiator_if.sv
// Bus bundles for the addr-line-en to Wishbone initiator.
//   fw_rv_addr_line_en_req_if           : requester side (t_*), master = requester,
//                                         slave = bridge
//   fw_rv_addr_line_en_wb_initiator_if  : Wishbone side (i_*), master = initiator,
//                                         slave = target
// Signal names keep the block's documented port names.

interface fw_rv_addr_line_en_req_if #(
  parameter int unsigned ADR_WIDTH = 30,
  parameter int unsigned DAT_WIDTH = 32
);
  logic [ADR_WIDTH-1:0] t_adr;
  logic [DAT_WIDTH-1:0] t_dat_w;
  logic                 t_we;
  logic                 t_valid;
  logic                 t_ready;
  logic [DAT_WIDTH-1:0] t_dat_r;
  logic                 t_err;

  modport master (
    output t_adr, t_dat_w, t_we, t_valid,
    input  t_ready, t_dat_r, t_err
  );

  modport slave (
    input  t_adr, t_dat_w, t_we, t_valid,
    output t_ready, t_dat_r, t_err
  );
endinterface

interface fw_rv_addr_line_en_wb_initiator_if #(
  parameter int unsigned ADR_WIDTH = 30,
  parameter int unsigned DAT_WIDTH = 32
);
  localparam int unsigned SEL_W = DAT_WIDTH / 8;

  logic [ADR_WIDTH+1:0] i_adr;
  logic [DAT_WIDTH-1:0] i_dat_w;
  logic [DAT_WIDTH-1:0] i_dat_r;
  logic                 i_cyc;
  logic                 i_stb;
  logic                 i_we;
  logic [SEL_W-1:0]     i_sel;
  logic                 i_ack;
  logic                 i_err;

  modport master (
    output i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel,
    input  i_dat_r, i_ack, i_err
  );

  modport slave (
    input  i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel,
    output i_dat_r, i_ack, i_err
  );
endinterface

// File: rtl/fw_rv_addr_line_en_wb_initiator.sv
// Bridges a valid/ready word-addressed request port onto a classic Wishbone
// initiator. One request at a time: IDLE captures, BUS runs the Wishbone
// cycle, RESP pulses t_ready for one clock.
// Ports:
//   clock, reset_n : single clock, asynchronous active-low reset
//   tgt            : request port (t_adr, t_dat_w, t_we, t_valid -> t_ready,
//                    t_dat_r, t_err)
//   wb             : Wishbone initiator (i_adr, i_dat_w, i_cyc, i_stb, i_we,
//                    i_sel <- i_dat_r, i_ack, i_err)
// TIMEOUT > 0 bounds the BUS phase to TIMEOUT clocks and then reports an error.

module fw_rv_addr_line_en_wb_initiator #(
  parameter int unsigned ADR_WIDTH = 30,
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic                               clock,
  input  logic                               reset_n,
  fw_rv_addr_line_en_req_if.slave            tgt,
  fw_rv_addr_line_en_wb_initiator_if.master  wb
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEL_W = DAT_WIDTH / 8;
  localparam bit          TO_EN = (TIMEOUT != 0);
  // Last BUS count before the timeout fires; unused when the timeout is off.
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e               state_q;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [DAT_WIDTH-1:0] dat_w_q;
  logic                 we_q;
  logic                 cyc_q;
  logic                 ready_q;
  logic                 err_q;
  logic [DAT_WIDTH-1:0] dat_r_q;
  logic [CNT_W-1:0]     cnt_q;

  // Request capture, Wishbone cycle control and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_w_q <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (tgt.t_valid) begin
            adr_q   <= tgt.t_adr;
            dat_w_q <= tgt.t_dat_w;
            we_q    <= tgt.t_we;
            cyc_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_BUS;
          end
        end

        ST_BUS: begin
          // Error wins over a simultaneous ack; both win over the timeout.
          if (wb.i_err) begin
            err_q   <= 1'b1;
            dat_r_q <= '0;
            cyc_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_RESP;
          end else if (wb.i_ack) begin
            err_q   <= 1'b0;
            dat_r_q <= we_q ? '0 : wb.i_dat_r;
            cyc_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_RESP;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            err_q   <= 1'b1;
            dat_r_q <= '0;
            cyc_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_RESP;
          end else if (TO_EN) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RESP: begin
          // t_valid seen here still belongs to the completing request.
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          cyc_q   <= 1'b0;
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Every output is a register or a fixed function of one.
  assign tgt.t_ready = ready_q;
  assign tgt.t_dat_r = dat_r_q;
  assign tgt.t_err   = err_q;

  assign wb.i_adr    = {adr_q, 2'b00};
  assign wb.i_dat_w  = dat_w_q;
  assign wb.i_we     = we_q;
  assign wb.i_cyc    = cyc_q;
  assign wb.i_stb    = cyc_q;
  assign wb.i_sel    = {SEL_W{cyc_q}};

endmodule

// File: doc/fw_rv_addr_line_en_wb_initiator.md
FW_RV_ADDR_LINE_EN_WB_INITIATOR -- requirements
Module: fw_rv_addr_line_en_wb_initiator

Interface
REQ-001 Parameter ADR_WIDTH, default 30: width of the addr-line-en word address (t_adr).
REQ-002 Parameter DAT_WIDTH, default 32: data width of both ports; fixed at 32.
REQ-003 Parameter TIMEOUT, default 0: bus-cycle limit in clocks; 0 disables the timeout.
REQ-004 Port: clock, in, 1, the only clock; all state updates on its rising edge.
REQ-005 Port: reset_n, in, 1, asynchronous active-low reset.
REQ-006 Port: t_adr, in, ADR_WIDTH, addr-line-en target word address.
REQ-007 Port: t_dat_w, in, 32, write data.
REQ-008 Port: t_we, in, 1, 1 = write, 0 = read.
REQ-009 Port: t_valid, in, 1, request valid; held by the requester until t_ready.
REQ-010 Port: t_ready, out, 1, one-cycle completion pulse.
REQ-011 Port: t_dat_r, out, 32, read data, valid while t_ready=1.
REQ-012 Port: t_err, out, 1, error flag, valid while t_ready=1.
REQ-013 Port: i_adr, out, ADR_WIDTH+2, Wishbone byte address = {captured t_adr, 2'b00}.
REQ-014 Ports: i_dat_w out 32; i_dat_r in 32; i_cyc out 1; i_stb out 1; i_we out 1; i_sel out 4; i_ack in 1; i_err in 1 -- Wishbone initiator port.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, BUS, RESP.
REQ-016 IDLE: t_valid=1 SHALL capture t_adr, t_dat_w and t_we into registers and move to BUS on the next edge.
REQ-017 BUS: i_cyc=i_stb=1, i_sel=4'hF, and i_adr/i_dat_w/i_we SHALL come from registers, stable for the whole cycle.
REQ-018 BUS: i_ack=1 or i_err=1 sampled on an edge SHALL move to RESP and register the outcome.
REQ-019 BUS, read terminated by ack: t_dat_r SHALL be set to i_dat_r from that edge.
REQ-020 BUS, write or error termination: t_dat_r SHALL be set to 0.
REQ-021 Simultaneous i_ack and i_err SHALL be treated as error: t_err=1, t_dat_r=0.
REQ-022 When TIMEOUT>0, a 16-bit counter SHALL clear on entry to BUS and increment each BUS cycle.
REQ-023 If the counter reaches TIMEOUT-1 with no ack/err on that edge, the block SHALL go to RESP with t_err=1 and t_dat_r=0.
REQ-024 A same-edge ack/err SHALL take priority over timeout.
REQ-025 i_cyc and i_stb SHALL be 0 in IDLE and RESP.
REQ-026 RESP SHALL last exactly one cycle with t_ready=1, then return to IDLE.
REQ-027 t_valid SHALL be ignored in BUS and RESP; in RESP it belongs to the completing request and SHALL NOT start a new transaction.
REQ-028 With a zero-wait target: t_valid at cycle 0, i_cyc/i_stb in cycle 1, t_ready in cycle 2.
REQ-029 Sustained throughput SHALL be one transaction per 3 cycles.
REQ-030 t_ready SHALL be 0 in IDLE and BUS; t_err and t_dat_r SHALL hold their last value outside RESP.

Reset
REQ-031 reset_n=0 SHALL immediately force: FSM=IDLE; i_cyc=i_stb=i_we=0; t_ready=t_err=0; t_dat_r=0; i_adr=0; i_dat_w=0; counter=0.
REQ-032 reset_n asserted mid-BUS SHALL drop i_cyc/i_stb asynchronously with no t_ready pulse.
REQ-033 The block SHALL leave reset in IDLE on the first rising edge after reset_n=1.

Verification
REQ-034 Zero-wait read: t_adr=0x3, t_we=0, ack same cycle as stb, i_dat_r=0xDEADBEEF -> i_adr=0xC; t_ready pulses in cycle 2 with t_dat_r=0xDEADBEEF, t_err=0.
REQ-035 Write with 3 wait states: t_dat_w=0x12345678, t_we=1 -> i_dat_w/i_we stable 4 cycles; t_ready one cycle after the ack edge; t_dat_r=0, t_err=0.
REQ-036 i_err and i_ack together on a read -> t_err=1, t_dat_r=0, single t_ready pulse.
REQ-037 TIMEOUT=8, target never acks -> i_cyc high exactly 8 cycles, then t_ready=1, t_err=1; next request completes normally.
REQ-038 Back-to-back: t_valid held high continuously across two requests -> exactly two Wishbone cycles, no request issued from the RESP cycle.
REQ-039 reset_n low during BUS -> i_cyc=0 immediately, no t_ready; a request after release completes normally.
